// File: rtl/com_fifo_buffer_pkg.sv
// Shared constants for the COM byte buffer: default depths, byte width and
// the TX pacing state encodings.
package com_fifo_buffer_pkg;

    localparam int BYTE_W            = 8;
    localparam int RX_DEPTH_LOG2_DEF = 4;
    localparam int TX_DEPTH_LOG2_DEF = 4;

    // TX pacing states, 2-bit legacy encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_WAIT  = 2'd3;

    // Number of FIFO entries for a given log2 depth
    function automatic int fifo_entries(input int depth_log2);
        return 1 << depth_log2;
    endfunction

endpackage

// File: rtl/com_fifo_buffer_if.sv
// Bus between the UART bit engines / serial_ctrl and the COM byte buffer.
// The buffer itself takes the slave view; the surrounding logic (or a bench)
// takes the master view.
interface com_fifo_buffer_if #(
    parameter int RX_DEPTH_LOG2 = 4
);
    // RX side
    logic                     rxdReady_i;
    logic [7:0]               rxdData_i;
    logic                     rxPop_i;
    logic                     rxValid_o;
    logic [7:0]               rxData_o;
    logic [RX_DEPTH_LOG2:0]   rxCount_o;
    logic                     rxOverrun_o;
    logic                     overrunClr_i;
    // TX side
    logic                     txPush_i;
    logic [7:0]               txData_i;
    logic                     txFull_o;
    logic                     txEmpty_o;
    logic                     txdBusy_i;
    logic                     txdStart_o;
    logic [7:0]               txdData_o;
    // Interrupt
    logic                     int_o;

    modport slave (
        input  rxdReady_i, rxdData_i, rxPop_i, overrunClr_i,
        input  txPush_i, txData_i, txdBusy_i,
        output rxValid_o, rxData_o, rxCount_o, rxOverrun_o,
        output txFull_o, txEmpty_o, txdStart_o, txdData_o, int_o
    );

    modport master (
        output rxdReady_i, rxdData_i, rxPop_i, overrunClr_i,
        output txPush_i, txData_i, txdBusy_i,
        input  rxValid_o, rxData_o, rxCount_o, rxOverrun_o,
        input  txFull_o, txEmpty_o, txdStart_o, txdData_o, int_o
    );

endinterface

// File: rtl/com_fifo_buffer_sync_fifo.sv
// Single-clock show-ahead FIFO. Pointers carry one extra MSB so that full and
// empty are distinguished by the occupancy count. A push while full is only
// taken when a pop retires the head in the same cycle; a pop while empty is
// ignored, so a push into an empty FIFO is never bypassed to the output.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int               DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [DEPTH_LOG2:0] r_wptr;
    logic [DEPTH_LOG2:0] r_rptr;
    logic [DEPTH_LOG2:0] w_count;
    logic                w_pop_ok;
    logic                w_push_ok;

    assign w_count   = r_wptr - r_rptr;
    assign count     = w_count;
    assign full      = w_count[DEPTH_LOG2];
    assign empty     = (w_count == '0);
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);
    assign rdata     = r_mem[r_rptr[DEPTH_LOG2-1:0]];

    // Advance write/read pointers on accepted push/pop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
        end
    end

    // Storage write; contents need no reset since empty masks them
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr[DEPTH_LOG2-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/com_fifo_buffer.sv
// COM byte buffer between the UART bit engines and serial_ctrl.
// RX: every receiver strobe lands in a FIFO, head shown ahead for the CPU,
// with a sticky overrun flag when a byte has to be dropped.
// TX: bytes from serial_ctrl are queued and handed to the transmitter one at
// a time, paced by txdBusy_i.
//
// TX state | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for a queued byte and an idle transmitter
// START    | txdStart_o high for this single cycle, txdData_o holds byte
// GAP      | one cycle for the transmitter's registered busy to rise
// WAIT     | transmitter busy; return to IDLE once it drops
module com_fifo_buffer
    import com_fifo_buffer_pkg::*;
#(
    parameter int RX_DEPTH_LOG2 = RX_DEPTH_LOG2_DEF,
    parameter int TX_DEPTH_LOG2 = TX_DEPTH_LOG2_DEF
) (
    input  logic              clk,
    input  logic              rst,
    com_fifo_buffer_if.slave  bus
);

    // RX path
    logic [BYTE_W-1:0]      w_rx_rdata;
    logic                   w_rx_empty;
    logic                   w_rx_full;
    logic [RX_DEPTH_LOG2:0] w_rx_count;
    logic                   w_rx_drop;
    logic                   r_rx_overrun;

    // TX path
    logic [BYTE_W-1:0]      w_tx_rdata;
    logic                   w_tx_empty;
    logic                   w_tx_full;
    logic [TX_DEPTH_LOG2:0] w_tx_count;
    logic                   w_tx_pop;
    logic [1:0]             r_state;
    logic [1:0]             w_next;
    logic                   r_txd_start;
    logic [BYTE_W-1:0]      r_txd_data;

    sync_fifo #(
        .WIDTH      (BYTE_W),
        .DEPTH_LOG2 (RX_DEPTH_LOG2)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.rxdReady_i),
        .pop   (bus.rxPop_i),
        .wdata (bus.rxdData_i),
        .rdata (w_rx_rdata),
        .empty (w_rx_empty),
        .full  (w_rx_full),
        .count (w_rx_count)
    );

    // A strobe is lost only when full and nothing leaves in the same cycle
    assign w_rx_drop = bus.rxdReady_i && w_rx_full && !bus.rxPop_i;

    // Sticky overrun flag; a new drop outranks a coincident clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_overrun <= 1'b0;
        end else if (w_rx_drop) begin
            r_rx_overrun <= 1'b1;
        end else if (bus.overrunClr_i) begin
            r_rx_overrun <= 1'b0;
        end
    end

    assign bus.rxValid_o   = !w_rx_empty;
    assign bus.rxData_o    = w_rx_rdata;
    assign bus.rxCount_o   = w_rx_count;
    assign bus.rxOverrun_o = r_rx_overrun;
    assign bus.int_o       = !w_rx_empty;

    sync_fifo #(
        .WIDTH      (BYTE_W),
        .DEPTH_LOG2 (TX_DEPTH_LOG2)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.txPush_i),
        .pop   (w_tx_pop),
        .wdata (bus.txData_i),
        .rdata (w_tx_rdata),
        .empty (w_tx_empty),
        .full  (w_tx_full),
        .count (w_tx_count)
    );

    // Head leaves the queue only from IDLE with an idle transmitter
    assign w_tx_pop = (r_state == ST_IDLE) && (w_tx_count != '0) && !bus.txdBusy_i;

    // Next-state decode for the TX pacing FSM
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_tx_pop) w_next = ST_START;
            ST_START: w_next = ST_GAP;
            ST_GAP:   w_next = ST_WAIT;
            ST_WAIT:  if (!bus.txdBusy_i) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // State, registered start strobe (high exactly while in START) and byte latch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_txd_start <= 1'b0;
            r_txd_data  <= '0;
        end else begin
            r_state     <= w_next;
            r_txd_start <= (w_next == ST_START);
            if (w_tx_pop) begin
                r_txd_data <= w_tx_rdata;
            end
        end
    end

    assign bus.txFull_o   = w_tx_full;
    assign bus.txEmpty_o  = w_tx_empty && (r_state == ST_IDLE);
    assign bus.txdStart_o = r_txd_start;
    assign bus.txdData_o  = r_txd_data;

endmodule
